// File: rtl/proc_oci_pkg.sv
// Shared constants and types for the OCI debug-trace unpacking path.
//   CODE_W : bits per trace code
//   DEPTH  : maximum codes per packed word
//   CNT_W  : width of the code count / code index
//   STAT_W : width of the emitted-code statistics counter
//   BUF_W  : packed buffer width (CODE_W * DEPTH)
package proc_oci_pkg;

  localparam int CODE_W = 2;
  localparam int DEPTH  = 15;
  localparam int CNT_W  = 4;
  localparam int STAT_W = 16;
  localparam int BUF_W  = CODE_W * DEPTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/proc_oci_sat_counter.sv
// Saturating up-counter.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears the count
//   inc   : add one this cycle (ignored once the count is all ones)
//   count : current count
module proc_oci_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/proc_oci_dct_unpacker.sv
// Consumer end of the OCI trace packing path. Accepts packed words of up to
// DEPTH two-bit trace codes and emits them one per cycle over a valid/ready
// handshake. Once test_ending is seen, no further words are accepted; the
// word in flight drains and test_has_ended is raised (sticky until reset).
//   clk, reset     : single clock, synchronous active-high reset
//   in_valid/ready : packed-word handshake (dct_buffer, dct_count)
//   test_ending    : level request for end-of-test drain
//   code_valid/ready, code, code_index, code_last : serialized code output
//   test_has_ended : drain complete
//   codes_emitted  : saturating count of code handshakes
// in_ready depends combinationally on code_ready so the next word can be
// taken in the same cycle as the last code of the current one; the sink must
// not derive code_ready from in_ready.
module proc_oci_dct_unpacker
  import proc_oci_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BUF_W-1:0]  dct_buffer,
  input  logic [CNT_W-1:0]  dct_count,
  input  logic              test_ending,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [CODE_W-1:0] code,
  output logic [CNT_W-1:0]  code_index,
  output logic              code_last,
  output logic              test_has_ended,
  output logic [STAT_W-1:0] codes_emitted
);

  state_e             state_q,     state_d;
  logic [BUF_W-1:0]   shift_q,     shift_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   index_q,     index_d;
  logic               ending_q,    ending_d;

  logic accept;
  logic load;
  logic code_hs;
  logic last_code;

  assign last_code = (state_q == SHIFT) && (remaining_q == CNT_W'(1));
  assign code_hs   = (state_q == SHIFT) && code_ready;

  assign in_ready = !reset && !ending_q && !test_ending &&
                    ((state_q == IDLE) || (last_code && code_ready));

  assign accept = in_valid && in_ready;
  // An empty word is consumed but produces nothing.
  assign load   = accept && (dct_count != '0);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    ending_d    = ending_q | test_ending;

    case (state_q)
      IDLE: begin
        if (ending_d) state_d = DONE;
      end
      SHIFT: begin
        if (code_hs) begin
          shift_d     = shift_q >> CODE_W;
          remaining_d = remaining_q - 1'b1;
          index_d     = index_q + 1'b1;
          if (last_code) state_d = ending_d ? DONE : IDLE;
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase

    // Acceptance is only possible in IDLE or on the final code handshake
    // with no drain pending, so it safely overrides the choices above.
    if (load) begin
      shift_d     = dct_buffer;
      remaining_d = dct_count;
      index_d     = '0;
      state_d     = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      remaining_q <= '0;
      index_q     <= '0;
      ending_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      ending_q    <= ending_d;
    end
  end

  assign code_valid     = (state_q == SHIFT);
  assign code           = shift_q[CODE_W-1:0];
  assign code_index     = index_q;
  assign code_last      = last_code;
  assign test_has_ended = (state_q == DONE);

  proc_oci_sat_counter #(
    .W (STAT_W)
  ) u_stat (
    .clk   (clk),
    .reset (reset),
    .inc   (code_hs),
    .count (codes_emitted)
  );

endmodule

// File: tb/tb_proc_oci_dct_unpacker.sv
// Directed testbench for proc_oci_dct_unpacker.
module tb_proc_oci_dct_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        code_valid;
  logic        code_ready;
  logic [1:0]  code;
  logic [3:0]  code_index;
  logic        code_last;
  logic        test_has_ended;
  logic [15:0] codes_emitted;

  int checks = 0;
  int errors = 0;

  logic [29:0] word_a;
  logic [1:0]  exp5 [5];

  always #5 clk = ~clk;

  proc_oci_dct_unpacker dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .code_valid     (code_valid),
    .code_ready     (code_ready),
    .code           (code),
    .code_index     (code_index),
    .code_last      (code_last),
    .test_has_ended (test_has_ended),
    .codes_emitted  (codes_emitted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; leave time 1 unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp5[0] = 2'd1; exp5[1] = 2'd2; exp5[2] = 2'd3; exp5[3] = 2'd0; exp5[4] = 2'd2;
    word_a = '0;
    for (int i = 0; i < 15; i++) word_a[2*i +: 2] = 2'(i % 4);

    reset = 1'b1; in_valid = 1'b1; dct_buffer = 30'h3FF; dct_count = 4'd3;
    test_ending = 1'b0; code_ready = 1'b1;
    tick; tick;
    // Reset state
    chk("rst_in_ready", in_ready, 0);
    chk("rst_code_valid", code_valid, 0);
    chk("rst_code", code, 0);
    chk("rst_index", code_index, 0);
    chk("rst_last", code_last, 0);
    chk("rst_ended", test_has_ended, 0);
    chk("rst_emitted", codes_emitted, 0);

    // Single word 0xE4, 4 codes
    reset = 1'b0; in_valid = 1'b1; dct_buffer = 30'h0000_00E4; dct_count = 4'd4;
    #1 chk("w1_in_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("w1_valid", code_valid, 1);
      chk("w1_code", code, i);
      chk("w1_index", code_index, i);
      chk("w1_last", code_last, (i == 3));
      tick;
    end
    chk("w1_idle_valid", code_valid, 0);
    chk("w1_emitted", codes_emitted, 4);

    // Back-to-back words of 15 and 2 codes
    in_valid = 1'b1; dct_buffer = word_a; dct_count = 4'd15;
    tick;
    dct_buffer = 30'h7; dct_count = 4'd2;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("b2b_valid", code_valid, 1);
      chk("b2b_code", code, i % 4);
      chk("b2b_index", code_index, i);
      chk("b2b_in_ready", in_ready, (i == 14));
      tick;
      if (i == 14) in_valid = 1'b0;
    end
    chk("b2b_w2_valid0", code_valid, 1);
    chk("b2b_w2_code0", code, 3);
    chk("b2b_w2_index0", code_index, 0);
    chk("b2b_w2_last0", code_last, 0);
    tick;
    chk("b2b_w2_valid1", code_valid, 1);
    chk("b2b_w2_code1", code, 1);
    chk("b2b_w2_index1", code_index, 1);
    chk("b2b_w2_last1", code_last, 1);
    tick;
    chk("b2b_idle", code_valid, 0);
    chk("b2b_emitted", codes_emitted, 21);

    // Backpressure mid-word and on the last code
    in_valid = 1'b1; dct_buffer = 30'h239; dct_count = 4'd5;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_code_pre", code, exp5[i]);
      tick;
    end
    code_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_hold_code", code, 3);
      chk("bp_hold_index", code_index, 2);
      chk("bp_hold_valid", code_valid, 1);
      chk("bp_hold_in_ready", in_ready, 0);
      tick;
    end
    chk("bp_hold_emitted", codes_emitted, 23);
    code_ready = 1'b1;
    for (int i = 2; i < 4; i++) begin
      chk("bp_code_post", code, exp5[i]);
      chk("bp_index_post", code_index, i);
      tick;
    end
    // Last code stalled with an empty word offered
    code_ready = 1'b0; in_valid = 1'b1; dct_buffer = 30'h3FFF_FFFF; dct_count = 4'd0;
    #1 chk("bp_last_in_ready_stall", in_ready, 0);
    chk("bp_last_code", code, 2);
    chk("bp_last_flag", code_last, 1);
    tick;
    chk("bp_last_held", code_valid, 1);
    code_ready = 1'b1;
    #1 chk("bp_last_in_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
    chk("bp_drop_valid", code_valid, 0);
    chk("bp_emitted", codes_emitted, 26);

    // Empty word then single-code word
    in_valid = 1'b1; dct_buffer = 30'h3FFF_FFFF; dct_count = 4'd0;
    tick;
    chk("empty_valid", code_valid, 0);
    dct_buffer = 30'h2; dct_count = 4'd1;
    tick;
    in_valid = 1'b0;
    chk("one_valid", code_valid, 1);
    chk("one_code", code, 2);
    chk("one_last", code_last, 1);
    chk("one_index", code_index, 0);
    tick;
    chk("one_idle", code_valid, 0);
    chk("one_emitted", codes_emitted, 27);

    // Reset with 6 codes remaining
    in_valid = 1'b1; dct_buffer = 30'hFFFF; dct_count = 4'd8;
    tick;
    in_valid = 1'b0;
    tick; tick;
    chk("mid_remaining_index", code_index, 2);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_rst_valid", code_valid, 0);
    chk("mid_rst_emitted", codes_emitted, 0);
    chk("mid_rst_code", code, 0);
    in_valid = 1'b1; dct_buffer = 30'h1; dct_count = 4'd1;
    #1 chk("mid_rst_in_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
    chk("mid_new_code", code, 1);
    chk("mid_new_last", code_last, 1);
    tick;
    chk("mid_new_emitted", codes_emitted, 1);

    // test_ending pulse during a 5-code word
    in_valid = 1'b1; dct_buffer = 30'h239; dct_count = 4'd5;
    tick;
    chk("end_code0", code, exp5[0]);
    test_ending = 1'b1; dct_count = 4'd3;
    #1 chk("end_in_ready_pulse", in_ready, 0);
    tick;
    test_ending = 1'b0;
    for (int i = 1; i < 5; i++) begin
      #1;
      chk("end_valid", code_valid, 1);
      chk("end_code", code, exp5[i]);
      chk("end_in_ready", in_ready, 0);
      chk("end_not_yet", test_has_ended, 0);
      tick;
    end
    chk("end_has_ended", test_has_ended, 1);
    chk("end_valid_off", code_valid, 0);
    chk("end_emitted", codes_emitted, 6);
    tick; tick;
    #1 chk("end_sticky", test_has_ended, 1);
    chk("end_in_ready_done", in_ready, 0);
    reset = 1'b1; in_valid = 1'b0;
    tick;
    reset = 1'b0;
    chk("end_rst_cleared", test_has_ended, 0);

    // test_ending in IDLE: DONE next cycle
    test_ending = 1'b1;
    tick;
    test_ending = 1'b0;
    chk("idle_end", test_has_ended, 1);
    chk("idle_end_valid", code_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
